// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer that decouples upstream and downstream handshakes with registered outputs.
// Latency: one cycle from an accepted input to its appearance on out_*.
// Backpressure: in_ready is a register, dropping only once the skid entry is occupied; no comb path from out_ready.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   flush               drop every held entry and any entry offered this cycle
//   in_valid/in_ready   upstream handshake, carrying in_pc / in_ins
//   out_valid/out_ready downstream handshake, carrying out_pc / out_ins (pc=0, ins=NOP_INS when idle)
//   stall_cnt           saturating count of cycles with out_valid=1 and out_ready=0
module pipe_skid_stage #(
  parameter int PC_W  = 32,
  parameter int INS_W = 32,
  parameter logic [INS_W-1:0] NOP_INS = 32'h0000_0013,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [INS_W-1:0] in_ins,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [INS_W-1:0] out_ins,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [PC_W-1:0]  main_pc;
  logic [INS_W-1:0] main_ins;
  logic [PC_W-1:0]  skid_pc;
  logic [INS_W-1:0] skid_ins;

  logic in_fire;
  logic out_fire;
  logic stall;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign stall    = out_valid & ~out_ready;

  // main is scrubbed to pc=0/NOP whenever it goes invalid, so the outputs
  // are straight register reads with no idle mux.
  assign out_pc  = main_pc;
  assign out_ins = main_ins;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_pc   <= '0;
      main_ins  <= NOP_INS;
      skid_pc   <= '0;
      skid_ins  <= NOP_INS;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      stall_cnt <= '0;
    end else begin
      // The counter keeps running through flush; it only clears on reset.
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      if (flush) begin
        // Any out_fire this cycle has already been taken downstream; any
        // in_fire is simply dropped.
        state     <= EMPTY;
        main_pc   <= '0;
        main_ins  <= NOP_INS;
        skid_pc   <= '0;
        skid_ins  <= NOP_INS;
        out_valid <= 1'b0;
        in_ready  <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              main_pc   <= in_pc;
              main_ins  <= in_ins;
              out_valid <= 1'b1;
              state     <= ONE;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_pc  <= in_pc;
              main_ins <= in_ins;
            end else if (in_fire) begin
              // Downstream stalled: park the new entry and close the input.
              skid_pc  <= in_pc;
              skid_ins <= in_ins;
              in_ready <= 1'b0;
              state    <= TWO;
            end else if (out_fire) begin
              main_pc   <= '0;
              main_ins  <= NOP_INS;
              out_valid <= 1'b0;
              state     <= EMPTY;
            end
          end
          TWO: begin
            if (out_fire) begin
              main_pc  <= skid_pc;
              main_ins <= skid_ins;
              skid_pc  <= '0;
              skid_ins <= NOP_INS;
              in_ready <= 1'b1;
              state    <= ONE;
            end
          end
          default: begin
            state     <= EMPTY;
            main_pc   <= '0;
            main_ins  <= NOP_INS;
            skid_pc   <= '0;
            skid_ins  <= NOP_INS;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
module tb_pipe_skid_stage;

  localparam int PC_W  = 32;
  localparam int INS_W = 32;
  localparam int CNT_W = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [PC_W-1:0]  in_pc;
  logic [INS_W-1:0] in_ins;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  out_pc;
  logic [INS_W-1:0] out_ins;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .PC_W(PC_W), .INS_W(INS_W), .NOP_INS(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ins(in_ins),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        e_ov;
    logic [31:0] e_pc;
    logic        e_ir;
    int          e_sc;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic add(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                     input logic ordy, input logic e_ov, input logic [31:0] e_pc,
                     input logic e_ir, input int e_sc);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.pc = pc; v.ordy = ordy;
    v.e_ov = e_ov; v.e_pc = e_pc; v.e_ir = e_ir; v.e_sc = e_sc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [31:0] pc, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_pc = pc; in_ins = ins_of(pc); out_ready = ordy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] next_pc;
    logic        fin, fout;

    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    // reset
    add(1, 0, 0, 32'h0,   0, 0, 32'h0,   1, 0);
    // streaming, out_ready=1
    for (int k = 0; k < 8; k++)
      add(0, 0, 1, 32'h100 + 32'(4 * k), 1, 1, 32'h100 + 32'(4 * k), 1, 0);
    add(0, 0, 0, 32'h0,   1, 0, 32'h0,   1, 0);
    // backpressure into TWO, then drain
    add(0, 0, 1, 32'h200, 0, 1, 32'h200, 1, 0);
    add(0, 0, 1, 32'h204, 0, 1, 32'h200, 0, 1);
    add(0, 0, 1, 32'h208, 0, 1, 32'h200, 0, 2);
    add(0, 0, 0, 32'h0,   1, 1, 32'h204, 1, 2);
    add(0, 0, 0, 32'h0,   1, 0, 32'h0,   1, 2);
    // flush in TWO with a competing input 0x300
    add(0, 0, 1, 32'h2F0, 0, 1, 32'h2F0, 1, 2);
    add(0, 0, 1, 32'h2F4, 0, 1, 32'h2F0, 0, 3);
    add(0, 1, 1, 32'h300, 1, 0, 32'h0,   1, 3);
    add(0, 0, 0, 32'h0,   1, 0, 32'h0,   1, 3);
    // simultaneous in_fire and out_fire in ONE
    add(0, 0, 1, 32'h400, 0, 1, 32'h400, 1, 3);
    add(0, 0, 1, 32'h404, 1, 1, 32'h404, 1, 3);
    add(0, 0, 0, 32'h0,   1, 0, 32'h0,   1, 3);

    tick();
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
      tick();
      check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
      check($sformatf("vec%0d out_pc", i), out_pc, vecs[i].e_pc);
      check($sformatf("vec%0d out_ins", i), out_ins, vecs[i].e_ov ? ins_of(vecs[i].e_pc) : NOP);
      check($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].e_ir});
      check($sformatf("vec%0d stall_cnt", i), {28'b0, stall_cnt}, 32'(vecs[i].e_sc));
    end

    // Random handshakes: order, no loss, no duplication against a queue model.
    next_pc = 32'h1000;
    for (int c = 0; c < 300; c++) begin
      drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), next_pc, 1'($urandom_range(0, 3) != 0));
      #1;
      fin  = in_valid & in_ready;
      fout = out_valid & out_ready;
      if (fout) begin
        if (q.size() == 0) check("rand unexpected out", out_pc, 32'hFFFF_FFFF);
        else begin
          check("rand order pc", out_pc, q[0]);
          check("rand order ins", out_ins, ins_of(q[0]));
          void'(q.pop_front());
        end
      end
      if (fin) begin
        q.push_back(next_pc);
        next_pc = next_pc + 32'd4;
      end
      tick();
    end
    check("rand backlog bound", 32'(q.size()) <= 32'd2 ? 32'd1 : 32'd0, 32'd1);

    // Saturation in TWO, then reset overriding flush and handshakes.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    check("flush empties", {31'b0, out_valid}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 32'h500, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h504, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int c = 0; c < 20; c++) tick();
    check("sat stall_cnt", {28'b0, stall_cnt}, 32'd15);
    check("sat held pc", out_pc, 32'h500);
    check("sat in_ready", {31'b0, in_ready}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h600, 1'b1);
    tick();
    check("rst stall_cnt", {28'b0, stall_cnt}, 32'd0);
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst in_ready", {31'b0, in_ready}, 32'd1);
    check("rst out_pc", out_pc, 32'h0);
    check("rst out_ins", out_ins, NOP);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    check("post-rst out_valid", {31'b0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
